// File: rtl/gate_truth_table_capture_pkg.sv
// Shared gate definitions: gate IDs, reference truth tables and sweep FSM states.
// Truth-table bit order is tt[{a,b}] = y, the same as the mux gate library data input.
package gate_truth_table_capture_pkg;

  localparam logic [2:0] GATE_NONE = 3'd0;
  localparam logic [2:0] GATE_AND  = 3'd1;
  localparam logic [2:0] GATE_OR   = 3'd2;
  localparam logic [2:0] GATE_NAND = 3'd3;
  localparam logic [2:0] GATE_NOR  = 3'd4;
  localparam logic [2:0] GATE_XOR  = 3'd5;
  localparam logic [2:0] GATE_XNOR = 3'd6;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } state_e;

endpackage

// File: rtl/gate_truth_table_capture_decode.sv
// Combinational classifier: maps a captured 4-bit truth table to {valid, gate_id}.
module gate_tt_decode
  import gate_truth_table_capture_pkg::*;
(
  input  logic [3:0] i_tt,
  output logic [2:0] o_gate_id,
  output logic       o_valid
);

  always_comb begin
    o_gate_id = GATE_NONE;
    o_valid   = 1'b0;
    case (i_tt)
      TT_AND:  begin o_gate_id = GATE_AND;  o_valid = 1'b1; end
      TT_OR:   begin o_gate_id = GATE_OR;   o_valid = 1'b1; end
      TT_NAND: begin o_gate_id = GATE_NAND; o_valid = 1'b1; end
      TT_NOR:  begin o_gate_id = GATE_NOR;  o_valid = 1'b1; end
      TT_XOR:  begin o_gate_id = GATE_XOR;  o_valid = 1'b1; end
      TT_XNOR: begin o_gate_id = GATE_XNOR; o_valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_capture.sv
// Sweeps an external 2-input gate through 00,01,10,11, rebuilds its truth table and classifies it.
// Define GATE_CAPTURE_CONFIRM_EN to run two passes and flag disagreement on the mismatch output.
module gate_truth_table_capture
  import gate_truth_table_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] tt,
  output logic [2:0] gate_id,
  output logic       valid
`ifdef GATE_CAPTURE_CONFIRM_EN
  ,
  output logic       mismatch
`endif
);

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES);

  state_e     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_sh;
  logic [1:0] r_ab;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_tt;
  logic [2:0] r_gate_id;
  logic       r_valid;

  logic [3:0] w_sh_next;
  logic [2:0] w_gate_id;
  logic       w_valid;
  logic       w_last_pass;
  logic       w_mismatch;

`ifdef GATE_CAPTURE_CONFIRM_EN
  logic       r_pass;
  logic [3:0] r_sh_first;
  logic       r_mismatch;

  assign w_last_pass = r_pass;
  assign w_mismatch  = (w_sh_next != r_sh_first);
  assign mismatch    = r_mismatch;
`else
  assign w_last_pass = 1'b1;
  assign w_mismatch  = 1'b0;
`endif

  // Shadow including the bit being sampled this edge, so DONE sees all four bits.
  always_comb begin
    w_sh_next        = r_sh;
    w_sh_next[r_idx] = dut_y;
  end

  gate_tt_decode u_decode (
    .i_tt      (w_sh_next),
    .o_gate_id (w_gate_id),
    .o_valid   (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_ab      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tt      <= '0;
      r_gate_id <= GATE_NONE;
      r_valid   <= 1'b0;
`ifdef GATE_CAPTURE_CONFIRM_EN
      r_pass     <= 1'b0;
      r_sh_first <= '0;
      r_mismatch <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StApply;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ab    <= '0;
`ifdef GATE_CAPTURE_CONFIRM_EN
            r_pass  <= 1'b0;
`endif
          end
        end
        StApply: begin
          if (r_cnt != SettleLast) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_cnt <= '0;
            r_sh  <= w_sh_next;
            if (r_idx != 2'd3) begin
              r_idx <= r_idx + 2'd1;
              r_ab  <= r_idx + 2'd1;
            end else if (!w_last_pass) begin
              r_idx <= '0;
              r_ab  <= '0;
`ifdef GATE_CAPTURE_CONFIRM_EN
              r_pass     <= 1'b1;
              r_sh_first <= w_sh_next;
`endif
            end else begin
              r_state   <= StDone;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_ab      <= '0;
              r_tt      <= w_sh_next;
              r_gate_id <= w_gate_id;
              r_valid   <= w_valid & ~w_mismatch;
`ifdef GATE_CAPTURE_CONFIRM_EN
              r_mismatch <= w_mismatch;
`endif
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dut_a   = r_ab[1];
  assign dut_b   = r_ab[0];
  assign busy    = r_busy;
  assign done    = r_done;
  assign tt      = r_tt;
  assign gate_id = r_gate_id;
  assign valid   = r_valid;

endmodule

// File: tb/tb_gate_truth_table_capture.sv
// Self-checking bench for gate_truth_table_capture: a modelled gate under test driven by the
// sweep, compared against a boolean reference of the six known gates.
module tb_gate_truth_table_capture;

  localparam int unsigned S = 1;
`ifdef GATE_CAPTURE_CONFIRM_EN
  localparam int Passes = 2;
`else
  localparam int Passes = 1;
`endif
  localparam int SweepLat = 4 * (int'(S) + 1) * Passes + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       dut_y;
  logic       dut_a;
  logic       dut_b;
  logic       busy;
  logic       done;
  logic [3:0] tt;
  logic [2:0] gate_id;
  logic       valid;
`ifdef GATE_CAPTURE_CONFIRM_EN
  logic       mismatch;
`endif

  logic [3:0] gate_fn;
  int         n_checks;
  int         n_fail;
  int         lat;
  logic [1:0] q_stim[$];

  assign dut_y = gate_fn[{dut_a, dut_b}];

  gate_truth_table_capture #(
    .SETTLE_CYCLES (S)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .dut_y   (dut_y),
    .dut_a   (dut_a),
    .dut_b   (dut_b),
    .busy    (busy),
    .done    (done),
    .tt      (tt),
    .gate_id (gate_id),
    .valid   (valid)
`ifdef GATE_CAPTURE_CONFIRM_EN
    ,
    .mismatch (mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gate_eval(input int g, input logic a, input logic b);
    case (g)
      1:       return a & b;
      2:       return a | b;
      3:       return ~(a & b);
      4:       return ~(a | b);
      5:       return a ^ b;
      6:       return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] gate_table(input int g);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) t[i] = gate_eval(g, logic'(i / 2), logic'(i % 2));
    return t;
  endfunction

  function automatic void ref_decode(input logic [3:0] t, output logic [2:0] id, output logic v);
    id = 3'd0;
    v  = 1'b0;
    for (int g = 1; g <= 6; g++) begin
      if (gate_table(g) == t) begin
        id = 3'(g);
        v  = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] ref_stim();
    logic [63:0] v = '0;
    for (int p = 0; p < Passes; p++)
      for (int i = 0; i < 4; i++)
        for (int r = 0; r <= int'(S); r++) v = {v[61:0], 2'(i)};
    return v;
  endfunction

  function automatic logic [63:0] obs_stim();
    logic [63:0] v = '0;
    foreach (q_stim[k]) v = {v[61:0], q_stim[k]};
    return v;
  endfunction

  // Starts a sweep on the next edge and runs until done (bounded); fn2 applies from pass two.
  task automatic sweep(input logic [3:0] fn, input logic [3:0] fn2);
    gate_fn = fn;
    start   = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    q_stim.delete();
    for (int c = 1; c <= SweepLat + 4; c++) begin
      if (c == 4 * (int'(S) + 1) + 1) gate_fn = fn2;
      if (done) begin
        lat = c;
        break;
      end
      q_stim.push_back({dut_a, dut_b});
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    gate_fn = 4'h0;
    repeat (3) tick();
    n_checks++;
    if ({dut_a, dut_b, busy, done, valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=00000", {dut_a, dut_b, busy, done, valid});
    end
    n_checks++;
    if (tt !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_tt got=%b exp=0000", tt);
    end
    n_checks++;
    if (gate_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_gate_id got=%0d exp=0", gate_id);
    end
`ifdef GATE_CAPTURE_CONFIRM_EN
    n_checks++;
    if (mismatch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mismatch got=%b exp=0", mismatch);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and();
    sweep(gate_table(1), gate_table(1));
    n_checks++;
    if (lat != SweepLat) begin
      n_fail++;
      $display("FAIL and_latency got=%0d exp=%0d", lat, SweepLat);
    end
    n_checks++;
    if (obs_stim() !== ref_stim()) begin
      n_fail++;
      $display("FAIL and_stimulus got=%h exp=%h", obs_stim(), ref_stim());
    end
    n_checks++;
    if (tt !== 4'b1000) begin
      n_fail++;
      $display("FAIL and_tt got=%b exp=1000", tt);
    end
    n_checks++;
    if ({valid, gate_id} !== 4'b1001) begin
      n_fail++;
      $display("FAIL and_class got=%b exp=1001", {valid, gate_id});
    end
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL and_done_pulse got=%b exp=00", {done, busy});
    end
  endtask

  task automatic test_gate_sequence();
    int seq[3] = '{5, 6, 4};
    foreach (seq[k]) begin
      sweep(gate_table(seq[k]), gate_table(seq[k]));
      n_checks++;
      if (lat != SweepLat) begin
        n_fail++;
        $display("FAIL seq_latency gate=%0d got=%0d exp=%0d", seq[k], lat, SweepLat);
      end
      n_checks++;
      if (tt !== gate_table(seq[k])) begin
        n_fail++;
        $display("FAIL seq_tt gate=%0d got=%b exp=%b", seq[k], tt, gate_table(seq[k]));
      end
      n_checks++;
      if ({valid, gate_id} !== {1'b1, 3'(seq[k])}) begin
        n_fail++;
        $display("FAIL seq_class got=%b exp=%b", {valid, gate_id}, {1'b1, 3'(seq[k])});
      end
      tick();
    end
  endtask

  task automatic test_const_one();
    sweep(4'hF, 4'hF);
    n_checks++;
    if (tt !== 4'b1111) begin
      n_fail++;
      $display("FAIL const1_tt got=%b exp=1111", tt);
    end
    n_checks++;
    if ({valid, gate_id} !== 4'b0000) begin
      n_fail++;
      $display("FAIL const1_class got=%b exp=0000", {valid, gate_id});
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int   ndone = 0;
    int   first = 0;
    logic busy10 = 1'b1;
    logic busy11 = 1'b0;
    gate_fn = gate_table(1);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3 || c == 10) start = 1'b1;
      if (c == 4 || c == 11) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
      if (c == 10) busy10 = busy;
      if (c == 11) busy11 = busy;
      tick();
    end
    n_checks++;
    if (ndone != 1 || first != SweepLat) begin
      n_fail++;
      $display("FAIL start_ignored got=%0d@%0d exp=1@%0d", ndone, first, SweepLat);
    end
    n_checks++;
    if ({busy10, busy11} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_busy got=%b exp=01", {busy10, busy11});
    end
    ndone = 0;
    for (int c = 0; c < SweepLat + 4; c++) begin
      if (done) begin
        ndone++;
        break;
      end
      tick();
    end
    n_checks++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL restart_done got=%0d exp=1", ndone);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    gate_fn = gate_table(5);
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dut_a, dut_b, busy, done, valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_ctrl got=%b exp=00000", {dut_a, dut_b, busy, done, valid});
    end
    n_checks++;
    if ({tt, gate_id} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_result got=%b exp=0000000", {tt, gate_id});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    for (int c = 0; c < SweepLat + 4; c++) begin
      if (done || busy) ndone++;
      tick();
    end
    n_checks++;
    if (ndone != 0) begin
      n_fail++;
      $display("FAIL midrst_no_done got=%0d exp=0", ndone);
    end
    sweep(gate_table(6), gate_table(6));
    n_checks++;
    if ({lat, tt, valid, gate_id} !== {SweepLat, 4'b1001, 1'b1, 3'd6}) begin
      n_fail++;
      $display("FAIL midrst_resweep got=%0d/%b/%b/%0d exp=%0d/1001/1/6", lat, tt, valid, gate_id,
               SweepLat);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] fn;
    logic [2:0] exp_id;
    logic       exp_v;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1) fn = gate_table(int'($urandom_range(1, 6)));
      else fn = 4'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      sweep(fn, fn);
      ref_decode(fn, exp_id, exp_v);
      n_checks++;
      if (lat != SweepLat) begin
        n_fail++;
        $display("FAIL rand_latency fn=%b got=%0d exp=%0d", fn, lat, SweepLat);
      end
      n_checks++;
      if (tt !== fn) begin
        n_fail++;
        $display("FAIL rand_tt got=%b exp=%b", tt, fn);
      end
      n_checks++;
      if ({valid, gate_id} !== {exp_v, exp_id}) begin
        n_fail++;
        $display("FAIL rand_class fn=%b got=%b exp=%b", fn, {valid, gate_id}, {exp_v, exp_id});
      end
`ifdef GATE_CAPTURE_CONFIRM_EN
      n_checks++;
      if (mismatch !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_mismatch got=%b exp=0", mismatch);
      end
`endif
      tick();
    end
  endtask

`ifdef GATE_CAPTURE_CONFIRM_EN
  task automatic test_confirm();
    sweep(gate_table(2), gate_table(3));
    n_checks++;
    if (lat != 8 * (int'(S) + 1) + 1) begin
      n_fail++;
      $display("FAIL confirm_latency got=%0d exp=%0d", lat, 8 * (int'(S) + 1) + 1);
    end
    n_checks++;
    if ({tt, mismatch, valid} !== {4'b0111, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL confirm_result got=%b exp=011110", {tt, mismatch, valid});
    end
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_and();
    test_gate_sequence();
    test_const_one();
    test_start_ignored();
    test_reset_mid();
    test_random();
`ifdef GATE_CAPTURE_CONFIRM_EN
    test_confirm();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
